// File: rtl/dm_store_unit_pkg.sv
// Shared types and constants for the data-memory store path.
package dm_store_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_WID = 4;

    localparam logic [BE_WID-1:0] BE_W  = 4'b1111;
    localparam logic [BE_WID-1:0] BE_H0 = 4'b0011;
    localparam logic [BE_WID-1:0] BE_H1 = 4'b1100;
    localparam logic [BE_WID-1:0] BE_B0 = 4'b0001;
    localparam logic [BE_WID-1:0] BE_B1 = 4'b0010;
    localparam logic [BE_WID-1:0] BE_B2 = 4'b0100;
    localparam logic [BE_WID-1:0] BE_B3 = 4'b1000;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_W    = 2'd1,
        ST_H    = 2'd2,
        ST_B    = 2'd3
    } st_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BE_WID-1:0] be;
    } st_lane_t;

endpackage

// File: rtl/dm_store_unit_if.sv
// Data-memory write port: head-of-queue request with ack handshake.
interface dm_store_unit_if #(
    parameter int unsigned AW = 32
);
    logic          req;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          ack;

    modport master (output req, addr, wdata, be, input ack);
    modport slave  (input req, addr, wdata, be, output ack);
endinterface

// File: rtl/dm_store_unit_store_align.sv
// Store op select, alignment check and lane formatting (combinational).
module dm_store_unit_store_align
    import dm_store_unit_pkg::*;
(
    input  logic        sw,
    input  logic        sh,
    input  logic        sb,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic        legal_c,
    output logic        misalign_c,
    output st_lane_t    lane_c
);

    st_op_e op;

    always_comb begin
        op         = ST_NONE;
        misalign_c = 1'b0;
        lane_c     = '0;
        if (sw)      op = ST_W;
        else if (sh) op = ST_H;
        else if (sb) op = ST_B;

        case (op)
            ST_W: begin
                misalign_c  = (addr_lo != 2'b00);
                lane_c.be   = BE_W;
                lane_c.data = wdata;
            end
            ST_H: begin
                misalign_c  = addr_lo[0];
                lane_c.be   = addr_lo[1] ? BE_H1 : BE_H0;
                lane_c.data = {2{wdata[15:0]}};
            end
            ST_B: begin
                case (addr_lo)
                    2'd0:    lane_c.be = BE_B0;
                    2'd1:    lane_c.be = BE_B1;
                    2'd2:    lane_c.be = BE_B2;
                    default: lane_c.be = BE_B3;
                endcase
                lane_c.data = {4{wdata[7:0]}};
            end
            default: ;
        endcase
        legal_c = (op != ST_NONE) && !misalign_c;
    end

endmodule

// File: rtl/dm_store_unit.sv
// MEM-stage store queue: formats stores, buffers them, drains to DM, flags load hazards.
module dm_store_unit
    import dm_store_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sw,
    input  logic          sh,
    input  logic          sb,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          st_stall,
    output logic          st_misalign,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_conflict,
    dm_store_unit_if.master dm
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          legal_c;
    logic          misalign_c;
    st_lane_t      lane_c;

    logic [AW-3:0] waddr_q [DEPTH];
    st_lane_t      lane_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          misalign_q;

    logic do_enq, do_xfer, hit;
    logic unused_ld_lo;

    dm_store_unit_store_align u_store_align (
        .sw         (sw),
        .sh         (sh),
        .sb         (sb),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .legal_c    (legal_c),
        .misalign_c (misalign_c),
        .lane_c     (lane_c)
    );

    // Full blocks enqueue even when the head drains this cycle; the store retries.
    assign st_stall = (count_q == CW'(DEPTH));
    assign do_enq   = legal_c && !st_stall;
    assign do_xfer  = (count_q != '0) && dm.ack;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                waddr_q[i] <= '0;
                lane_q[i]  <= '0;
            end
            valid_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_c;
            if (do_xfer) begin
                valid_q[rptr_q] <= 1'b0;
                rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
            end
            if (do_enq) begin
                waddr_q[wptr_q] <= addr[AW-1:2];
                lane_q[wptr_q]  <= lane_c;
                valid_q[wptr_q] <= 1'b1;
                wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
            end
            case ({do_enq, do_xfer})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign st_misalign = misalign_q;
    assign dm.req      = (count_q != '0);
    assign dm.addr     = {waddr_q[rptr_q], 2'b00};
    assign dm.wdata    = lane_q[rptr_q].data;
    assign dm.be       = lane_q[rptr_q].be;

    // Word-granular hazard against queued entries only.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (waddr_q[i] == ld_addr[AW-1:2])) hit = 1'b1;
        end
    end

    assign ld_conflict  = ld_valid && hit;
    assign unused_ld_lo = ^ld_addr[1:0];

endmodule

// File: tb/tb_dm_store_unit.sv
// Directed self-checking bench for dm_store_unit.
module tb_dm_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        sw, sh, sb;
    logic [31:0] addr, wdata;
    logic        st_stall, st_misalign;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_conflict;

    int n_checks = 0;
    int n_errors = 0;

    dm_store_unit_if #(.AW(32)) dm_if ();

    dm_store_unit #(.DEPTH(2), .AW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .sh          (sh),
        .sb          (sb),
        .addr        (addr),
        .wdata       (wdata),
        .st_stall    (st_stall),
        .st_misalign (st_misalign),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .dm          (dm_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_st(input logic w, input logic h, input logic b,
                            input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sw = w; sh = h; sb = b; addr = a; wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] be_exp;
        logic [7:0] byte_v;

        reset = 1'b0; sw = 0; sh = 0; sb = 0; addr = '0; wdata = '0;
        ld_valid = 1'b0; ld_addr = '0; dm_if.ack = 1'b0;
        tick(); tick();
        check("rst_req",      32'(dm_if.req),   32'd0);
        check("rst_addr",     dm_if.addr,       32'h0);
        check("rst_wdata",    dm_if.wdata,      32'h0);
        check("rst_be",       32'(dm_if.be),    32'h0);
        check("rst_stall",    32'(st_stall),    32'd0);
        check("rst_misalign", 32'(st_misalign), 32'd0);
        @(negedge clk); reset = 1'b1;

        // sb to the top byte lane, ack held high
        drive_st(0, 0, 1, 32'h103, 32'h0000_00A5);
        dm_if.ack = 1'b1;
        tick();
        check("sb_req",   32'(dm_if.req), 32'd1);
        check("sb_addr",  dm_if.addr,     32'h100);
        check("sb_be",    32'(dm_if.be),  32'h8);
        check("sb_wdata", dm_if.wdata,    32'hA5A5_A5A5);
        drive_st(0, 0, 0, 32'h0, 32'h0);
        tick();
        check("sb_drained", 32'(dm_if.req), 32'd0);

        // every byte lane back-to-back with continuous ack
        for (int n = 0; n < 4; n++) begin
            byte_v = 8'h5A + 8'(n);
            drive_st(0, 0, 1, 32'h10 + 32'(n), {24'hFFFFFF, byte_v});
            tick();
            be_exp = 4'(1 << n);
            check($sformatf("sb_lane%0d_be", n), 32'(dm_if.be), 32'(be_exp));
            check($sformatf("sb_lane%0d_wd", n), dm_if.wdata, {4{byte_v}});
            check($sformatf("sb_lane%0d_ad", n), dm_if.addr, 32'h10);
        end
        drive_st(0, 0, 0, 32'h0, 32'h0);
        tick();
        check("lanes_drained", 32'(dm_if.req), 32'd0);
        dm_if.ack = 1'b0;

        // sh upper half, then lower half
        drive_st(0, 1, 0, 32'h22, 32'hDEAD_1234);
        tick();
        check("sh_hi_addr",  dm_if.addr,    32'h20);
        check("sh_hi_be",    32'(dm_if.be), 32'hC);
        check("sh_hi_wdata", dm_if.wdata,   32'h1234_1234);
        drive_st(0, 1, 0, 32'h44, 32'h0000_BEEF);
        dm_if.ack = 1'b1;
        tick();
        check("sh_lo_addr",  dm_if.addr,    32'h44);
        check("sh_lo_be",    32'(dm_if.be), 32'h3);
        check("sh_lo_wdata", dm_if.wdata,   32'hBEEF_BEEF);
        drive_st(0, 0, 0, 32'h0, 32'h0);
        tick();
        check("sh_drained", 32'(dm_if.req), 32'd0);
        dm_if.ack = 1'b0;

        // misaligned sw: one-cycle pulse, nothing queued
        drive_st(1, 0, 0, 32'h41, 32'h1111_1111);
        tick();
        check("mis_pulse", 32'(st_misalign), 32'd1);
        check("mis_req",   32'(dm_if.req),   32'd0);
        check("mis_stall", 32'(st_stall),    32'd0);
        drive_st(0, 0, 0, 32'h0, 32'h0);
        tick();
        check("mis_clear", 32'(st_misalign), 32'd0);
        check("mis_req2",  32'(dm_if.req),   32'd0);

        // sw wins over legal sb: misaligned sw dropped
        drive_st(1, 0, 1, 32'h301, 32'h2222_2222);
        tick();
        check("prio_mis", 32'(st_misalign), 32'd1);
        check("prio_req", 32'(dm_if.req),   32'd0);
        drive_st(0, 1, 1, 32'h302, 32'h0000_ABCD);
        tick();
        check("prio_sh_be", 32'(dm_if.be), 32'hC);
        dm_if.ack = 1'b1;
        drive_st(0, 0, 0, 32'h0, 32'h0);
        tick();
        check("prio_drained", 32'(dm_if.req), 32'd0);
        dm_if.ack = 1'b0;

        // fill, stall, then drain in order with a held third store
        drive_st(1, 0, 0, 32'h200, 32'hAAAA_0001);
        tick();
        check("fill1_stall", 32'(st_stall), 32'd0);
        drive_st(1, 0, 0, 32'h204, 32'hAAAA_0002);
        tick();
        check("fill2_stall", 32'(st_stall), 32'd1);
        drive_st(1, 0, 0, 32'h208, 32'hAAAA_0003);
        tick();
        check("held_stall", 32'(st_stall),  32'd1);
        check("held_head",  dm_if.addr,     32'h200);
        check("held_data",  dm_if.wdata,    32'hAAAA_0001);
        @(negedge clk); dm_if.ack = 1'b1;
        tick();
        check("drain1_stall", 32'(st_stall), 32'd0);
        check("drain1_addr",  dm_if.addr,    32'h204);
        check("drain1_data",  dm_if.wdata,   32'hAAAA_0002);
        tick();
        check("drain2_req",  32'(dm_if.req), 32'd1);
        check("drain2_addr", dm_if.addr,     32'h208);
        check("drain2_data", dm_if.wdata,    32'hAAAA_0003);
        drive_st(0, 0, 0, 32'h0, 32'h0);
        tick();
        check("drain3_req", 32'(dm_if.req), 32'd0);
        dm_if.ack = 1'b0;

        // load hazard detection
        drive_st(1, 0, 0, 32'h80, 32'h8080_8080);
        tick();
        drive_st(1, 0, 0, 32'h90, 32'h9090_9090);
        ld_valid = 1'b1; ld_addr = 32'h82; #1;
        check("ldc_hit", 32'(ld_conflict), 32'd1);
        ld_addr = 32'h84; #1;
        check("ldc_miss", 32'(ld_conflict), 32'd0);
        ld_addr = 32'h90; #1;
        check("ldc_same_cycle", 32'(ld_conflict), 32'd0);
        ld_valid = 1'b0; ld_addr = 32'h80; #1;
        check("ldc_novalid", 32'(ld_conflict), 32'd0);
        tick();
        ld_valid = 1'b1; ld_addr = 32'h93; #1;
        check("ldc_second", 32'(ld_conflict), 32'd1);
        check("two_q_stall", 32'(st_stall),   32'd1);

        // reset with two entries queued
        drive_st(0, 0, 0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        ld_addr = 32'h80; #1;
        check("rst2_req",   32'(dm_if.req),   32'd0);
        check("rst2_stall", 32'(st_stall),    32'd0);
        check("rst2_addr",  dm_if.addr,       32'h0);
        check("rst2_be",    32'(dm_if.be),    32'h0);
        check("rst2_wdata", dm_if.wdata,      32'h0);
        check("rst2_ldc",   32'(ld_conflict), 32'd0);
        @(negedge clk); reset = 1'b1; ld_valid = 1'b0;
        dm_if.ack = 1'b1;
        tick();
        check("rst2_ack_ignored", 32'(dm_if.req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
